host_io_arbiter: RTL and testbench

//  Shares the single 512-bit host IO channel (op/io_addr/common_data_bus_*) between I-cache, D-cache and FFT accelerator.

---
 rtl/host_io_arbiter_pkg.sv | 33 +++
 rtl/host_io_arbiter_accel_burst_ctr.sv | 41 ++++
 rtl/host_io_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_host_io_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_io_arbiter_pkg.sv
// Shared types and constants for the host IO arbiter: FSM state encoding,
// host op encoding, line geometry and accelerator burst length.
package host_io_pkg;

    localparam int LINE_W       = 512;
    localparam int LINE_BYTES   = 64;
    localparam int ACCEL_BLOCKS = 128;
    localparam int IDX_W        = 7;

    typedef enum logic [3:0] {
        IDLE,
        INSTR_RD,
        INSTR_RD_DONE,
        DATA_RD,
        DATA_RD_DONE,
        DATA_WR,
        ACCEL_RD,
        ACCEL_RD_DONE,
        ACCEL_WR
    } arb_state_t;

    // 2'b10 is reserved on the host interface and never produced.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b11
    } op_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:6], 6'b0};
    endfunction

endpackage

// File: rtl/host_io_arbiter_accel_burst_ctr.sv
// Accelerator burst line counter plus host address generation for the
// current line and the line after it (32-bit wrap, base low bits ignored).
module accel_burst_ctr
    import host_io_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [31:0]      base_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic [31:0]      line_addr_o,
    output logic [31:0]      next_addr_o
);

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign last_o      = (idx_q == IDX_W'(ACCEL_BLOCKS - 1));
    assign line_addr_o = line_align(base_i) + 32'(idx_q) * 32'(LINE_BYTES);
    assign next_addr_o = line_addr_o + 32'(LINE_BYTES);

endmodule

// File: rtl/host_io_arbiter.sv
// Arbitrates the 512-bit host IO channel between I-cache, D-cache and the FFT
// accelerator. Define ACCEL_PREEMPT_EN to let cache requests cut into accel bursts.
module host_io_arbiter
    import host_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [31:0]       ic_addr,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [31:0]       dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    input  logic              accel_req,
    input  logic              accel_we,
    input  logic [31:0]       accel_base,
    input  logic [LINE_W-1:0] accel_wdata,
    output logic [IDX_W-1:0]  accel_blk_idx,
    output logic              accel_blk_valid,
    output logic              accel_done,
    output logic [LINE_W-1:0] ic_rdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic [LINE_W-1:0] accel_rdata,
    input  logic [LINE_W-1:0] common_data_bus_in,
    input  logic              tx_done,
    input  logic              rd_valid,
    output logic [1:0]        op,
    output logic [31:0]       io_addr,
    output logic [LINE_W-1:0] common_data_bus_out,
    output arb_state_t        dbg_state
);

`ifdef ACCEL_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    arb_state_t        state_q;
    op_t               op_q;
    logic [31:0]       io_addr_q;
    logic [LINE_W-1:0] rdata_q;
    logic              ic_done_q, dc_done_q, blk_valid_q, accel_done_q;
    logic              burst_act_q, burst_we_q;

    logic [IDX_W-1:0]  idx;
    logic              ctr_last, ctr_clr, ctr_inc, wr_adv, cache_pend;
    logic [31:0]       acc_line_addr, acc_next_addr;

    // Read bursts advance idx one cycle late so blk_idx still names the line
    // during its blk_valid pulse; the same holds for clearing after accel_done.
    assign cache_pend = dc_req | ic_req;
    assign wr_adv     = (state_q == ACCEL_WR) && tx_done && !ctr_last;
    assign ctr_clr    = accel_done_q;
    assign ctr_inc    = (blk_valid_q && !accel_done_q) || wr_adv;

    accel_burst_ctr u_ctr (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (ctr_clr),
        .inc_i       (ctr_inc),
        .base_i      (accel_base),
        .idx_o       (idx),
        .last_o      (ctr_last),
        .line_addr_o (acc_line_addr),
        .next_addr_o (acc_next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_NONE;
            io_addr_q    <= '0;
            rdata_q      <= '0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
            blk_valid_q  <= 1'b0;
            accel_done_q <= 1'b0;
            burst_act_q  <= 1'b0;
            burst_we_q   <= 1'b0;
        end else begin
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
            blk_valid_q  <= 1'b0;
            accel_done_q <= 1'b0;
            case (state_q)
                // A requester whose done is pulsing may still hold req this cycle.
                IDLE: begin
                    if (dc_req && !dc_done_q) begin
                        state_q   <= dc_we ? DATA_WR : DATA_RD;
                        op_q      <= dc_we ? OP_WRITE : OP_READ;
                        io_addr_q <= line_align(dc_addr);
                    end else if (ic_req && !ic_done_q) begin
                        state_q   <= INSTR_RD;
                        op_q      <= OP_READ;
                        io_addr_q <= line_align(ic_addr);
                    end else if (burst_act_q) begin
                        state_q   <= burst_we_q ? ACCEL_WR : ACCEL_RD;
                        op_q      <= burst_we_q ? OP_WRITE : OP_READ;
                        io_addr_q <= blk_valid_q ? acc_next_addr : acc_line_addr;
                    end else if (accel_req && !accel_done_q) begin
                        burst_act_q <= 1'b1;
                        burst_we_q  <= accel_we;
                        state_q     <= accel_we ? ACCEL_WR : ACCEL_RD;
                        op_q        <= accel_we ? OP_WRITE : OP_READ;
                        io_addr_q   <= acc_line_addr;
                    end else begin
                        op_q <= OP_NONE;
                    end
                end
                INSTR_RD, DATA_RD, ACCEL_RD: begin
                    if (tx_done) begin
                        rdata_q <= common_data_bus_in;
                        op_q    <= OP_NONE;
                        state_q <= (state_q == INSTR_RD) ? INSTR_RD_DONE :
                                   (state_q == DATA_RD)  ? DATA_RD_DONE : ACCEL_RD_DONE;
                    end
                end
                INSTR_RD_DONE: begin
                    if (rd_valid) begin
                        ic_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DATA_RD_DONE: begin
                    if (rd_valid) begin
                        dc_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DATA_WR: begin
                    if (tx_done) begin
                        dc_done_q <= 1'b1;
                        op_q      <= OP_NONE;
                        state_q   <= IDLE;
                    end
                end
                ACCEL_RD_DONE: begin
                    if (rd_valid) begin
                        blk_valid_q <= 1'b1;
                        if (ctr_last) begin
                            accel_done_q <= 1'b1;
                            burst_act_q  <= 1'b0;
                            state_q      <= IDLE;
                        end else if (PREEMPT && cache_pend) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= ACCEL_RD;
                            op_q      <= OP_READ;
                            io_addr_q <= acc_next_addr;
                        end
                    end
                end
                ACCEL_WR: begin
                    if (tx_done) begin
                        if (ctr_last) begin
                            accel_done_q <= 1'b1;
                            burst_act_q  <= 1'b0;
                            op_q         <= OP_NONE;
                            state_q      <= IDLE;
                        end else if (PREEMPT && cache_pend) begin
                            op_q    <= OP_NONE;
                            state_q <= IDLE;
                        end else begin
                            io_addr_q <= acc_next_addr;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    op_q    <= OP_NONE;
                end
            endcase
        end
    end

    always_comb begin
        common_data_bus_out = '0;
        if (op_q == OP_WRITE) begin
            common_data_bus_out = (state_q == ACCEL_WR) ? accel_wdata : dc_wdata;
        end
    end

    assign op              = op_q;
    assign io_addr         = io_addr_q;
    assign ic_rdata        = rdata_q;
    assign dc_rdata        = rdata_q;
    assign accel_rdata     = rdata_q;
    assign ic_done         = ic_done_q;
    assign dc_done         = dc_done_q;
    assign accel_blk_valid = blk_valid_q;
    assign accel_done      = accel_done_q;
    assign accel_blk_idx   = idx;
    assign dbg_state       = state_q;

`ifndef SYNTHESIS
    // Every requester must hold its request until its done pulse.
    a_ic_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q inside {INSTR_RD, INSTR_RD_DONE}) |-> ic_req);
    a_dc_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q inside {DATA_RD, DATA_RD_DONE, DATA_WR}) |-> dc_req);
    a_accel_hold: assert property (@(posedge clk) disable iff (rst)
        burst_act_q |-> accel_req);
`endif

endmodule

// File: tb/tb_host_io_arbiter.sv
// Self-checking bench for host_io_arbiter: a randomized host responder checks
// every transfer against an expected transfer list; requester tasks drive scenarios.
module tb_host_io_arbiter;
    import host_io_pkg::*;

    localparam int BUDGET = 6000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              ic_req, ic_done, dc_req, dc_we, dc_done;
    logic [31:0]       ic_addr, dc_addr, accel_base, io_addr;
    logic [LINE_W-1:0] dc_wdata, accel_wdata, ic_rdata, dc_rdata, accel_rdata;
    logic [LINE_W-1:0] common_data_bus_in, common_data_bus_out;
    logic              accel_req, accel_we, accel_blk_valid, accel_done;
    logic [IDX_W-1:0]  accel_blk_idx;
    logic              tx_done, rd_valid;
    logic [1:0]        op;
    arb_state_t        dbg_state;

    int total = 0;
    int bad = 0;
    logic [33:0]       exp_q[$];
    logic [LINE_W-1:0] exp_wr_q[$];
    logic [LINE_W-1:0] rd_line_q[$];
    int                blk_cnt = 0;
    int                accel_done_cnt = 0;
    logic [31:0]       acc_seed = 32'h0;

    // The accelerator buffer: line i holds the seed xor i in every word.
    assign accel_wdata = {16{acc_seed ^ {25'd0, accel_blk_idx}}};

    host_io_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_done(dc_done),
        .accel_req(accel_req), .accel_we(accel_we), .accel_base(accel_base), .accel_wdata(accel_wdata),
        .accel_blk_idx(accel_blk_idx), .accel_blk_valid(accel_blk_valid), .accel_done(accel_done),
        .ic_rdata(ic_rdata), .dc_rdata(dc_rdata), .accel_rdata(accel_rdata),
        .common_data_bus_in(common_data_bus_in), .tx_done(tx_done), .rd_valid(rd_valid),
        .op(op), .io_addr(io_addr), .common_data_bus_out(common_data_bus_out),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] acc_addr(input logic [31:0] base, input int i);
        return {base[31:6], 6'b0} + 32'(i) * 32'd64;
    endfunction

    function automatic logic [LINE_W-1:0] acc_line(input logic [31:0] seed, input int i);
        return {16{seed ^ 32'(i)}};
    endfunction

    function automatic void push_acc(input bit we, input logic [31:0] base, input logic [31:0] seed,
                                     input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({(we ? 2'b11 : 2'b01), acc_addr(base, i)});
            if (we) exp_wr_q.push_back(acc_line(seed, i));
        end
    endfunction

    // Host model: answers every READ/WRITE after a random delay, owes rd_valid
    // after each read, and sprinkles tx_done/rd_valid where they must be ignored.
    initial begin : host
        int dly;
        bit rv_owed;
        logic [33:0] e;
        logic [LINE_W-1:0] w, line;
        tx_done = 1'b0; rd_valid = 1'b0; common_data_bus_in = '0;
        dly = 0; rv_owed = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0; rd_valid = 1'b0;
            if (rst) begin
                dly = 0; rv_owed = 1'b0;
            end else begin
                total++;
                if (op == 2'b10 || io_addr[5:0] != 6'd0 || (op != 2'b11 && common_data_bus_out != '0)) begin
                    bad++;
                    $display("FAIL bus_rules op=%b io_addr=%h bus_out_nonzero=%0b", op, io_addr, common_data_bus_out != '0);
                end
                if (rv_owed) begin
                    if (dly == 0) begin
                        rd_valid = 1'b1;
                        tx_done  = ($urandom_range(0, 1) == 1);
                        rv_owed  = 1'b0;
                        dly      = $urandom_range(0, 2);
                    end else dly--;
                end else if (op == 2'b01 || op == 2'b11) begin
                    if (dly == 0) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_xfer got op=%b addr=%h expected none", op, io_addr);
                        end else begin
                            e = exp_q.pop_front();
                            if ({op, io_addr} !== e) begin
                                bad++;
                                $display("FAIL xfer got op=%b addr=%h expected op=%b addr=%h", op, io_addr, e[33:32], e[31:0]);
                            end
                        end
                        if (op == 2'b11) begin
                            total++;
                            w = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : '0;
                            if (common_data_bus_out !== w) begin
                                bad++;
                                $display("FAIL wdata got %h expected %h", common_data_bus_out[63:0], w[63:0]);
                            end
                        end else begin
                            for (int k = 0; k < 16; k++) line[k*32 +: 32] = $urandom;
                            common_data_bus_in = line;
                            rd_line_q.push_back(line);
                            rv_owed = 1'b1;
                        end
                        tx_done = 1'b1;
                        dly = $urandom_range(0, 2);
                    end else begin
                        dly--;
                        rd_valid = ($urandom_range(0, 3) == 0);
                    end
                end else begin
                    tx_done = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Read completions: each done/blk_valid must deliver the line the host supplied.
    initial begin : line_mon
        logic [LINE_W-1:0] l;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ic_done || (dc_done && !dc_we) || accel_blk_valid) begin
                    total++;
                    l = (rd_line_q.size() != 0) ? rd_line_q.pop_front() : '0;
                    if (ic_done && ic_rdata !== l) begin
                        bad++; $display("FAIL ic_rdata got %h expected %h", ic_rdata[63:0], l[63:0]);
                    end
                    if (dc_done && dc_rdata !== l) begin
                        bad++; $display("FAIL dc_rdata got %h expected %h", dc_rdata[63:0], l[63:0]);
                    end
                    if (accel_blk_valid && accel_rdata !== l) begin
                        bad++; $display("FAIL accel_rdata got %h expected %h", accel_rdata[63:0], l[63:0]);
                    end
                end
                if (accel_blk_valid) begin
                    total++;
                    if (accel_blk_idx !== IDX_W'(blk_cnt)) begin
                        bad++; $display("FAIL blk_idx got %0d expected %0d", accel_blk_idx, blk_cnt);
                    end
                    blk_cnt++;
                end
                if (accel_done) accel_done_cnt++;
            end
        end
    end

    task automatic ic_txn(input logic [31:0] addr);
        int n = 0;
        ic_addr = addr; ic_req = 1'b1;
        do begin @(negedge clk); n++; end while (!ic_done && n < BUDGET);
        total++;
        if (ic_done !== 1'b1) begin bad++; $display("FAIL ic_done_timeout got 0 expected 1 after %0d", n); end
        ic_req = 1'b0;
        @(negedge clk);
        total++;
        if (ic_done !== 1'b0) begin bad++; $display("FAIL ic_done_pulse got %b expected 0", ic_done); end
    endtask

    task automatic dc_txn(input bit we, input logic [31:0] addr, input logic [LINE_W-1:0] wdata);
        int n = 0;
        dc_we = we; dc_addr = addr; dc_wdata = wdata; dc_req = 1'b1;
        do begin @(negedge clk); n++; end while (!dc_done && n < BUDGET);
        total++;
        if (dc_done !== 1'b1) begin bad++; $display("FAIL dc_done_timeout got 0 expected 1 after %0d", n); end
        dc_req = 1'b0;
        @(negedge clk);
        total++;
        if (dc_done !== 1'b0) begin bad++; $display("FAIL dc_done_pulse got %b expected 0", dc_done); end
    endtask

    task automatic accel_txn(input bit we, input logic [31:0] base);
        int n = 0;
        accel_we = we; accel_base = base; accel_req = 1'b1;
        do begin @(negedge clk); n++; end while (!accel_done && n < BUDGET);
        total++;
        if (accel_done !== 1'b1) begin bad++; $display("FAIL accel_done_timeout got 0 expected 1 after %0d", n); end
        accel_req = 1'b0;
        @(negedge clk);
        total++;
        if (accel_blk_idx !== '0 || accel_done !== 1'b0) begin
            bad++; $display("FAIL accel_end got idx=%0d done=%b expected idx=0 done=0", accel_blk_idx, accel_done);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0 || rd_line_q.size() != 0) begin
            bad++; $display("FAIL %s_drain got exp=%0d lines=%0d expected 0 0", name, exp_q.size(), rd_line_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (op !== 2'b00 || io_addr !== 32'h0 || ic_rdata !== '0 || accel_blk_idx !== '0 ||
            ic_done !== 1'b0 || dc_done !== 1'b0 || accel_blk_valid !== 1'b0 || accel_done !== 1'b0 ||
            dbg_state !== IDLE || common_data_bus_out !== '0) begin
            bad++;
            $display("FAIL reset got op=%b addr=%h idx=%0d st=%0d expected all zero/IDLE", op, io_addr, accel_blk_idx, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ic_fill();
        logic [31:0] a;
        exp_q.push_back({2'b01, 32'h0});
        ic_txn(32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            exp_q.push_back({2'b01, a[31:6], 6'b0});
            ic_txn(a);
        end
        check_drained("ic_fill");
    endtask

    task automatic test_dc();
        logic [31:0] a;
        logic [LINE_W-1:0] w;
        bit we;
        exp_q.push_back({2'b11, 32'h3000_0000});
        exp_wr_q.push_back({64{8'hA5}});
        dc_txn(1'b1, 32'h3000_0000, {64{8'hA5}});
        for (int i = 0; i < 6; i++) begin
            a = $urandom; we = $urandom_range(0, 1);
            for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
            exp_q.push_back({(we ? 2'b11 : 2'b01), a[31:6], 6'b0});
            if (we) exp_wr_q.push_back(w);
            dc_txn(we, a, w);
        end
        check_drained("dc");
    endtask

    task automatic test_accel_load();
        int d0 = accel_done_cnt;
        blk_cnt = 0;
        push_acc(1'b0, 32'h1000_0000, 32'h0, 0, ACCEL_BLOCKS - 1);
        accel_txn(1'b0, 32'h1000_0000);
        total++;
        if (blk_cnt != ACCEL_BLOCKS || accel_done_cnt - d0 != 1) begin
            bad++; $display("FAIL accel_load got blk=%0d done=%0d expected 128 1", blk_cnt, accel_done_cnt - d0);
        end
        check_drained("accel_load");
    endtask

    task automatic test_priority();
        logic [31:0] da = $urandom;
        logic [31:0] ia = $urandom;
        acc_seed = $urandom;
        exp_q.push_back({2'b01, da[31:6], 6'b0});
        exp_q.push_back({2'b01, ia[31:6], 6'b0});
        push_acc(1'b1, 32'hFFFF_E07F, acc_seed, 0, ACCEL_BLOCKS - 1);
        fork
            dc_txn(1'b0, da, '0);
            ic_txn(ia);
            accel_txn(1'b1, 32'hFFFF_E07F);
        join
        check_drained("priority");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d0 = accel_done_cnt;
        logic [31:0] base = {$urandom_range(0, 32'h3FF_FFFF), 6'h15};
        blk_cnt = 0;
        push_acc(1'b0, base, 32'h0, 0, ACCEL_BLOCKS - 1);
        accel_we = 1'b0; accel_base = base; accel_req = 1'b1;
        do begin @(negedge clk); n++; end while (!(accel_blk_valid && accel_blk_idx == 7'd39) && n < BUDGET);
        total++;
        if (!(accel_blk_valid && accel_blk_idx == 7'd39)) begin
            bad++; $display("FAIL reset_mid_reach got idx=%0d expected 39", accel_blk_idx);
        end
        rst = 1'b1; accel_req = 1'b0;
        @(negedge clk);
        total++;
        if (op !== 2'b00 || accel_blk_idx !== '0 || accel_done !== 1'b0 || dbg_state !== IDLE) begin
            bad++; $display("FAIL reset_mid got op=%b idx=%0d done=%b expected 00 0 0", op, accel_blk_idx, accel_done);
        end
        exp_q.delete(); exp_wr_q.delete(); rd_line_q.delete();
        blk_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_acc(1'b0, base, 32'h0, 0, ACCEL_BLOCKS - 1);
        accel_txn(1'b0, base);
        total++;
        if (blk_cnt != ACCEL_BLOCKS || accel_done_cnt - d0 != 1) begin
            bad++; $display("FAIL reset_mid_restart got blk=%0d done=%0d expected 128 1", blk_cnt, accel_done_cnt - d0);
        end
        check_drained("reset_mid");
    endtask

    task automatic test_preempt();
        logic [31:0] base = $urandom;
        logic [31:0] da = $urandom;
        blk_cnt = 0;
`ifdef ACCEL_PREEMPT_EN
        push_acc(1'b0, base, 32'h0, 0, 10);
        exp_q.push_back({2'b01, da[31:6], 6'b0});
        push_acc(1'b0, base, 32'h0, 11, ACCEL_BLOCKS - 1);
`else
        push_acc(1'b0, base, 32'h0, 0, ACCEL_BLOCKS - 1);
        exp_q.push_back({2'b01, da[31:6], 6'b0});
`endif
        fork
            accel_txn(1'b0, base);
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!(accel_blk_valid && accel_blk_idx == 7'd9) && n < BUDGET);
                dc_txn(1'b0, da, '0);
            end
        join
        total++;
        if (blk_cnt != ACCEL_BLOCKS) begin
            bad++; $display("FAIL preempt_blocks got %0d expected 128", blk_cnt);
        end
        check_drained("preempt");
    endtask

    initial begin
        rst = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        accel_req = 1'b0; accel_we = 1'b0; accel_base = '0;
        test_reset();
        test_ic_fill();
        test_dc();
        test_accel_load();
        test_priority();
        test_reset_mid();
        test_preempt();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
